banked_mem: RTL and testbench

Four-bank, word-interleaved memory responder; the memory side of the cache controller's line fill and writeback traffic. Accepts one read or write per cycle and selects the bank from the address. While a bank is occupied it raises `busy` for that bank, and it raises `stall` for any request that targets that bank. Read data returns on a fixed two-cycle pipeline.

---
 rtl/banked_mem_if.sv | 22 ++
 rtl/banked_mem.sv | 99 +++++++++
 tb/tb_banked_mem.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/banked_mem_if.sv
// Request/response bundle for banked_mem: one read or write per cycle in,
// read data plus per-bank busy, stall and err flags out.
interface banked_mem_if;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        wr;
  logic        rd;
  logic [15:0] data_out;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, stall, busy, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, stall, busy, err
  );
endinterface

// File: rtl/banked_mem.sv
// Four-bank word-interleaved memory with per-bank occupancy counters and a
// two-stage read pipeline. Define BANKED_MEM_ALIGN_CHK_EN to flag odd addresses as errors.
module banked_mem #(
  parameter int DEPTH_LOG2  = 13,
  parameter int BANK_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  banked_mem_if.slave  bus
);

  localparam int         WORDS    = 4 << DEPTH_LOG2;
  localparam logic [2:0] LOAD_VAL = 3'(BANK_CYCLES - 1);

  logic [3:0][2:0]        cnt_r;
  logic [15:0]            mem_r [WORDS];
  logic                   s1_vld_r;
  logic                   s2_vld_r;
  logic [15:0]            s1_data_r;
  logic [15:0]            s2_data_r;

  logic                   req_s;
  logic                   illegal_s;
  logic                   accept_s;
  logic [1:0]             bank_s;
  logic [DEPTH_LOG2+1:0]  idx_s;
  logic [3:0]             busy_s;

`ifndef BANKED_MEM_ALIGN_CHK_EN
  // Alignment bit has no effect when the check is compiled out.
  logic align_unused_s;
  assign align_unused_s = bus.addr[0];
`endif

  // Request decode, legality and accept/stall/err generation.
  always_comb begin
    req_s  = bus.rd | bus.wr;
    bank_s = bus.addr[2:1];
    idx_s  = {bank_s, bus.addr[DEPTH_LOG2+2:3]};
`ifdef BANKED_MEM_ALIGN_CHK_EN
    illegal_s = req_s & ((bus.rd & bus.wr) | bus.addr[0]);
`else
    illegal_s = bus.rd & bus.wr;
`endif
    for (int i = 0; i < 4; i++) begin
      busy_s[i] = (cnt_r[i] != 3'd0);
    end
    // Error wins over stall; both are masked while reset is held.
    accept_s  = rst & req_s & ~illegal_s & ~busy_s[bank_s];
    bus.stall = rst & req_s & ~illegal_s &  busy_s[bank_s];
    bus.err   = rst & illegal_s;
    bus.busy  = busy_s;
    if (s2_vld_r) begin
      bus.data_out = s2_data_r;
    end else begin
      bus.data_out = 16'h0000;
    end
  end

  // Per-bank occupancy counters: load on accept (only when idle), else count down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (accept_s && (bank_s == 2'(i))) begin
          cnt_r[i] <= LOAD_VAL;
        end else if (cnt_r[i] != 3'd0) begin
          cnt_r[i] <= cnt_r[i] - 3'd1;
        end else begin
          cnt_r[i] <= 3'd0;
        end
      end
    end
  end

  // Read pipeline valid bits; cleared at once by reset to drop in-flight data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_r <= 1'b0;
      s2_vld_r <= 1'b0;
    end else begin
      s1_vld_r <= accept_s & bus.rd;
      s2_vld_r <= s1_vld_r;
    end
  end

  // Storage array and read data path; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept_s && bus.wr) begin
      mem_r[idx_s] <= bus.data_in;
    end
    if (accept_s && bus.rd) begin
      s1_data_r <= mem_r[idx_s];
    end
    s2_data_r <= s1_data_r;
  end

endmodule

// File: tb/tb_banked_mem.sv
// Directed self-checking bench for banked_mem: a BANK_CYCLES=4 instance for the
// main sequence and a BANK_CYCLES=1 instance for the back-to-back read-after-write case.
module tb_banked_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  banked_mem_if ifa ();
  banked_mem_if ifb ();

  banked_mem #(.DEPTH_LOG2(13), .BANK_CYCLES(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  banked_mem #(.DEPTH_LOG2(13), .BANK_CYCLES(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A: drive after the falling edge, settle, then check.
  task automatic cyc(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ifa.rd = r; ifa.wr = w; ifa.addr = a; ifa.data_in = d;
    #1;
  endtask

  task automatic cycb(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    ifb.rd = r; ifb.wr = w; ifb.addr = a; ifb.data_in = d;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  initial begin
    ifa.rd = 1'b0; ifa.wr = 1'b0; ifa.addr = 16'h0000; ifa.data_in = 16'h0000;
    ifb.rd = 1'b0; ifb.wr = 1'b0; ifb.addr = 16'h0000; ifb.data_in = 16'h0000;

    // Reset state, with an illegal request applied to show err is masked.
    #2 rst = 1'b0;
    #1;
    chk("rst_busy", {12'h000, ifa.busy}, 16'h0000);
    chk("rst_dout", ifa.data_out, 16'h0000);
    ifa.rd = 1'b1; ifa.wr = 1'b1;
    #1;
    chk("rst_err", {15'h0000, ifa.err}, 16'h0000);
    chk("rst_stall", {15'h0000, ifa.stall}, 16'h0000);
    @(negedge clk);
    ifa.rd = 1'b0; ifa.wr = 1'b0;
    rst = 1'b1;

    // Write then read back at bank 0 with occupancy window.
    cyc(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("t1_wr_stall", {15'h0000, ifa.stall}, 16'h0000);
    chk("t1_wr_err", {15'h0000, ifa.err}, 16'h0000);
    for (int i = 1; i <= 3; i++) begin
      idle(1);
      chk("t1_busy", {12'h000, ifa.busy}, 16'h0001);
    end
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t1_rd_stall", {15'h0000, ifa.stall}, 16'h0000);
    chk("t1_free", {12'h000, ifa.busy}, 16'h0000);
    idle(1);
    chk("t1_dout_t5", ifa.data_out, 16'h0000);
    idle(1);
    chk("t1_dout_t6", ifa.data_out, 16'hBEEF);
    idle(1);
    chk("t1_dout_t7", ifa.data_out, 16'h0000);

    // Interleaved writes then back-to-back reads across all four banks.
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b1, 16'h0040 + 16'(2 * i), 16'(i + 1));
      chk("t2_wr_stall", {15'h0000, ifa.stall}, 16'h0000);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 4) cyc(1'b1, 1'b0, 16'h0040 + 16'(2 * i), 16'h0000);
      else       idle(1);
      if (i < 4)  chk("t2_rd_stall", {15'h0000, ifa.stall}, 16'h0000);
      if (i >= 2) chk("t2_dout", ifa.data_out, 16'(i - 1));
    end

    // Held read against a busy bank stalls until the bank frees.
    cyc(1'b0, 1'b1, 16'h0008, 16'h5A5A);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
      chk("t3_stall", {15'h0000, ifa.stall}, 16'h0001);
    end
    cyc(1'b1, 1'b0, 16'h0008, 16'h0000);
    chk("t3_accept", {15'h0000, ifa.stall}, 16'h0000);

    // rd&wr errors: on a busy bank err wins, on an idle bank no state change.
    cyc(1'b1, 1'b1, 16'h0000, 16'h0000);
    chk("t4_err_busy", {15'h0000, ifa.err}, 16'h0001);
    chk("t4_stall_busy", {15'h0000, ifa.stall}, 16'h0000);
    cyc(1'b1, 1'b1, 16'h0002, 16'h0000);
    chk("t4_err_idle", {15'h0000, ifa.err}, 16'h0001);
    chk("t4_stall_idle", {15'h0000, ifa.stall}, 16'h0000);
    chk("t3_dout", ifa.data_out, 16'h5A5A);
    idle(1);
    chk("t4_busy", {12'h000, ifa.busy}, 16'h0001);
    chk("t4_dout_end", ifa.data_out, 16'h0000);

    // Misaligned read of word 0.
    idle(1);
    cyc(1'b0, 1'b1, 16'h0000, 16'h7777);
    idle(3);
    cyc(1'b1, 1'b0, 16'h0001, 16'h0000);
`ifdef BANKED_MEM_ALIGN_CHK_EN
    chk("t4_align_err", {15'h0000, ifa.err}, 16'h0001);
`else
    chk("t4_align_err", {15'h0000, ifa.err}, 16'h0000);
`endif
    idle(2);
`ifdef BANKED_MEM_ALIGN_CHK_EN
    chk("t4_align_dout", ifa.data_out, 16'h0000);
`else
    chk("t4_align_dout", ifa.data_out, 16'h7777);
`endif

    // Reset pulse while a read is in flight.
    idle(2);
    cyc(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("t5_accept", {15'h0000, ifa.stall}, 16'h0000);
    @(negedge clk);
    ifa.rd = 1'b0; ifa.wr = 1'b0; ifa.addr = 16'h0000;
    rst = 1'b0;
    #1;
    chk("t5_rst_busy", {12'h000, ifa.busy}, 16'h0000);
    chk("t5_rst_dout", ifa.data_out, 16'h0000);
    #2 rst = 1'b1;
    idle(1);
    chk("t5_dout_t2", ifa.data_out, 16'h0000);
    chk("t5_busy_t2", {12'h000, ifa.busy}, 16'h0000);

    // Single-cycle bank: read the cycle after a write sees the new data.
    cycb(1'b0, 1'b1, 16'h0020, 16'h1234);
    chk("t6_wr_stall", {15'h0000, ifb.stall}, 16'h0000);
    cycb(1'b1, 1'b0, 16'h0020, 16'h0000);
    chk("t6_rd_stall", {15'h0000, ifb.stall}, 16'h0000);
    chk("t6_rd_err", {15'h0000, ifb.err}, 16'h0000);
    chk("t6_busy", {12'h000, ifb.busy}, 16'h0000);
    cycb(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t6_dout_t1", ifb.data_out, 16'h0000);
    cycb(1'b0, 1'b0, 16'h0000, 16'h0000);
    chk("t6_dout_t2", ifb.data_out, 16'h1234);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
